// File: rtl/mc_config_loader_pkg.sv
// Shared definitions for the macrocell configuration loader and the array wrapper
// that slices configuration words into cellcore mux inputs.
package mc_cfg_pkg;

  localparam int         CFG_W    = 20;
  localparam logic [7:0] HDR_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WORD,
    ST_PAR,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } state_e;

  // Field layout of one configuration word; pt1 sits at bit 0 (first bit received).
  typedef struct packed {
    logic [1:0] gclk;
    logic [2:0] oe;
    logic       o;
    logic       fb;
    logic       storage;
    logic       d;
    logic       xor_inv;
    logic       xor_b;
    logic       xor_a;
    logic       pt5_func;
    logic       pt4_func;
    logic       gclr;
    logic       pt5;
    logic       pt4;
    logic       pt3;
    logic       pt2;
    logic       pt1;
  } cfg_fields_t;

endpackage

// File: rtl/mc_config_loader_cfg_shifter.sv
// Indexed bit writer: places each loaded bit at the position given by its bit counter
// and keeps a running parity over the bits loaded since the last clear.
module cfg_shifter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         bit_in,
  output logic [W-1:0] word,
  output logic         last,
  output logic         parity
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          par_q, par_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      par_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      par_q  <= par_d;
    end
  end

  // The word itself is never cleared, so it keeps the last value written until overwritten.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    par_d  = par_q;
    if (clear) begin
      cnt_d = '0;
      par_d = 1'b0;
    end else if (load) begin
      word_d[cnt_q] = bit_in;
      par_d         = par_q ^ bit_in;
      cnt_d         = cnt_q + 1'b1;
    end
  end

  assign word   = word_q;
  assign last   = (cnt_q == CW'(W - 1));
  assign parity = par_q;

endmodule

// File: rtl/mc_config_loader.sv
// Serial configuration sequencer: checks a framed fuse bitstream (header, words, parity)
// and issues one write strobe per macrocell configuration word.
module mc_config_loader
  import mc_cfg_pkg::*;
#(
  parameter int         NUM_MC = 16,
  parameter int         CFG_W  = mc_cfg_pkg::CFG_W,
  parameter logic [7:0] HDR    = HDR_SYNC,
  localparam int        AW     = (NUM_MC > 1) ? $clog2(NUM_MC) : 1
) (
  input  logic             clk_v,
  input  logic             rst_v,
  input  logic             start_v,
  input  logic             bit_v,
  input  logic             bit_valid_v,
  output logic             bit_ready_v,
  output logic [CFG_W-1:0] cfg_word_v,
  output logic [AW-1:0]    cfg_addr_v,
  output logic             cfg_we_v,
  output logic             busy_v,
  output logic             done_v,
  output logic             err_v
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    hdr_q, hdr_d;
  logic [2:0]    hdr_cnt_q, hdr_cnt_d;
  logic [7:0]    hdr_next;
  logic          xfer;
  logic          sh_clear, sh_load, sh_last, sh_parity;

  always_ff @(posedge clk_v) begin
    if (rst_v) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      hdr_q     <= '0;
      hdr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      hdr_q     <= hdr_d;
      hdr_cnt_q <= hdr_cnt_d;
    end
  end

  assign bit_ready_v = (state_q == ST_HDR) || (state_q == ST_WORD) || (state_q == ST_PAR);
  assign xfer        = bit_valid_v && bit_ready_v;
  assign hdr_next    = {hdr_q[6:0], bit_v};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hdr_d     = hdr_q;
    hdr_cnt_d = hdr_cnt_q;
    sh_clear  = 1'b0;
    sh_load   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_v) begin
          state_d   = ST_HDR;
          addr_d    = '0;
          hdr_d     = '0;
          hdr_cnt_d = '0;
          sh_clear  = 1'b1;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          hdr_d     = hdr_next;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == 3'd7) begin
            state_d = (hdr_next == HDR) ? ST_WORD : ST_ERR;
          end
        end
      end
      ST_WORD: begin
        if (xfer) begin
          sh_load = 1'b1;
          if (sh_last) begin
            state_d = ST_PAR;
          end
        end
      end
      ST_PAR: begin
        // Even parity: data parity XOR the parity bit must come out zero.
        if (xfer) begin
          state_d = (sh_parity ^ bit_v) ? ST_ERR : ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (addr_q == AW'(NUM_MC - 1)) begin
          state_d = ST_DONE;
        end else begin
          addr_d   = addr_q + 1'b1;
          sh_clear = 1'b1;
          state_d  = ST_WORD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cfg_shifter #(.W(CFG_W)) u_shifter (
    .clk    (clk_v),
    .rst    (rst_v),
    .clear  (sh_clear),
    .load   (sh_load),
    .bit_in (bit_v),
    .word   (cfg_word_v),
    .last   (sh_last),
    .parity (sh_parity)
  );

  // A reset landing on the commit cycle must not let the strobe escape.
  assign cfg_we_v   = (state_q == ST_COMMIT) && !rst_v;
  assign cfg_addr_v = addr_q;
  assign busy_v     = (state_q == ST_HDR) || (state_q == ST_WORD) ||
                      (state_q == ST_PAR) || (state_q == ST_COMMIT);
  assign done_v     = (state_q == ST_DONE);
  assign err_v      = (state_q == ST_ERR);

endmodule

// File: tb/tb_mc_config_loader.sv
// Self-checking bench: a 2-macrocell and a 16-macrocell loader share stimulus; frames are
// driven from a vector table plus hand sequences and judged against a frame-level model.
module tb_mc_config_loader;

  localparam int W = 20;

  logic clk_v = 1'b0;
  logic rst_v, start_v, bit_v, bit_valid_v;

  logic          s_ready, s_we, s_busy, s_done, s_err;
  logic [W-1:0]  s_word;
  logic [0:0]    s_addr;
  logic          l_ready, l_we, l_busy, l_done, l_err;
  logic [W-1:0]  l_word;
  logic [3:0]    l_addr;

  always #5 clk_v = ~clk_v;

  mc_config_loader #(.NUM_MC(2)) dut_s (
    .clk_v(clk_v), .rst_v(rst_v), .start_v(start_v), .bit_v(bit_v),
    .bit_valid_v(bit_valid_v), .bit_ready_v(s_ready), .cfg_word_v(s_word),
    .cfg_addr_v(s_addr), .cfg_we_v(s_we), .busy_v(s_busy), .done_v(s_done), .err_v(s_err)
  );

  mc_config_loader #(.NUM_MC(16)) dut_l (
    .clk_v(clk_v), .rst_v(rst_v), .start_v(start_v), .bit_v(bit_v),
    .bit_valid_v(bit_valid_v), .bit_ready_v(l_ready), .cfg_word_v(l_word),
    .cfg_addr_v(l_addr), .cfg_we_v(l_we), .busy_v(l_busy), .done_v(l_done), .err_v(l_err)
  );

  typedef struct {
    logic [7:0] hdr;
    int         bad_idx;
    bit         big;
    bit         gaps;
    bit         do_reset;
    int         exp_writes;
    bit         exp_done;
    bit         exp_err;
    int         exp_addr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] frame_words[16];
  logic         frame_par[16];
  logic [23:0]  s_wr[$];
  logic [23:0]  l_wr[$];
  logic [23:0]  exp_wr[$];
  bit           mdl_done, mdl_err;
  int           mdl_addr;

  // Write-strobe monitors, sampled mid-cycle.
  always @(negedge clk_v) begin
    if (s_we) s_wr.push_back({3'b000, s_addr, s_word});
    if (l_we) l_wr.push_back({l_addr, l_word});
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_v);
    #1;
  endtask

  // Holds the bit valid until the targeted loader is ready; returns just after the transfer edge.
  task automatic send_bit(input logic b, input bit big, input int gaps);
    bit r;
    int n;
    bit_valid_v = 1'b0;
    repeat (gaps) step();
    bit_v       = b;
    bit_valid_v = 1'b1;
    r = 1'b0;
    n = 0;
    while (!r && n < 64) begin
      @(negedge clk_v);
      r = big ? l_ready : s_ready;
      step();
      n++;
    end
    bit_valid_v = 1'b0;
    if (!r) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout actual=not_ready required=ready");
    end
  endtask

  task automatic send_word(input int i, input bit big, input bit gaps);
    for (int k = 0; k < W; k++) send_bit(frame_words[i][k], big, gaps ? int'($urandom_range(0, 5)) : 0);
    send_bit(frame_par[i], big, gaps ? int'($urandom_range(0, 5)) : 0);
  endtask

  task automatic send_header(input logic [7:0] h, input bit big, input bit gaps);
    for (int b = 7; b >= 0; b--) send_bit(h[b], big, gaps ? int'($urandom_range(0, 5)) : 0);
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    step();
    step();
    rst_v = 1'b0;
  endtask

  // Frame-level reference: which words get written and how the frame ends.
  task automatic model_frame(input logic [7:0] h, input int n);
    exp_wr.delete();
    mdl_done = 1'b0;
    mdl_err  = 1'b0;
    mdl_addr = 0;
    if (h != 8'hA5) begin
      mdl_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        int ones;
        ones = 0;
        for (int k = 0; k < W; k++) ones += int'(frame_words[i][k]);
        ones += int'(frame_par[i]);
        mdl_addr = i;
        if (ones % 2 != 0) begin
          mdl_err = 1'b1;
          break;
        end
        exp_wr.push_back({4'(i), frame_words[i]});
        if (i == n - 1) mdl_done = 1'b1;
      end
    end
  endtask

  task automatic compare_writes(input bit big, input string tag);
    logic [23:0] q[$];
    q = big ? l_wr : s_wr;
    checkOutput($sformatf("%s_nwrites", tag), q.size(), exp_wr.size());
    for (int j = 0; j < q.size() && j < exp_wr.size(); j++)
      checkOutput($sformatf("%s_write%0d", tag, j), q[j], exp_wr[j]);
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    n = v.big ? 16 : 2;
    if (v.do_reset) do_reset();
    for (int i = 0; i < n; i++) begin
      frame_words[i] = v.big ? W'($urandom) : ((i == 0) ? 20'h00001 : 20'hFFFFF);
      frame_par[i]   = (^frame_words[i]) ^ (i == v.bad_idx);
    end
    start_v = 1'b1;
    step();
    start_v = 1'b0;
    s_wr.delete();
    l_wr.delete();
    send_header(v.hdr, v.big, v.gaps);
    if (v.hdr == 8'hA5) begin
      for (int i = 0; i < n; i++) begin
        send_word(i, v.big, v.gaps);
        if (i == v.bad_idx) break;
      end
    end
    repeat (3) step();
  endtask

  task automatic check_vector(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    model_frame(v.hdr, v.big ? 16 : 2);
    @(negedge clk_v);
    checkOutput({t, "_done"}, v.big ? l_done : s_done, v.exp_done);
    checkOutput({t, "_err"}, v.big ? l_err : s_err, v.exp_err);
    checkOutput({t, "_model_done"}, mdl_done, v.exp_done);
    checkOutput({t, "_busy"}, v.big ? l_busy : s_busy, 0);
    checkOutput({t, "_ready"}, v.big ? l_ready : s_ready, 0);
    checkOutput({t, "_addr"}, v.big ? 32'(l_addr) : 32'(s_addr), v.exp_addr);
    checkOutput({t, "_model_addr"}, mdl_addr, v.exp_addr);
    checkOutput({t, "_model_nwrites"}, exp_wr.size(), v.exp_writes);
    if (v.hdr == 8'hA5)
      checkOutput({t, "_word"}, v.big ? l_word : s_word, frame_words[mdl_addr]);
    compare_writes(v.big, t);
    step();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'hA5, -1, 1'b0, 1'b0, 1'b1,  2, 1'b1, 1'b0,  1};
    vecs[1] = '{8'hA4, -1, 1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b1,  0};
    vecs[2] = '{8'hA5, -1, 1'b0, 1'b1, 1'b0,  2, 1'b1, 1'b0,  1};
    vecs[3] = '{8'hA5,  1, 1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b1,  1};
    vecs[4] = '{8'hA5,  0, 1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b1,  0};
    vecs[5] = '{8'h5A, -1, 1'b1, 1'b0, 1'b1,  0, 1'b0, 1'b1,  0};
    vecs[6] = '{8'hA5, -1, 1'b1, 1'b0, 1'b1, 16, 1'b1, 1'b0, 15};
    vecs[7] = '{8'hA5, -1, 1'b1, 1'b1, 1'b1, 16, 1'b1, 1'b0, 15};
    vecs[8] = '{8'hA5,  9, 1'b1, 1'b1, 1'b1,  9, 1'b0, 1'b1,  9};

    rst_v = 1'b1;
    start_v = 1'b0;
    bit_v = 1'b0;
    bit_valid_v = 1'b0;
    step();
    step();
    @(negedge clk_v);
    checkOutput("reset_ready", s_ready, 0);
    checkOutput("reset_word", s_word, 0);
    checkOutput("reset_addr", s_addr, 0);
    checkOutput("reset_we", s_we, 0);
    checkOutput("reset_busy", s_busy, 0);
    checkOutput("reset_done", s_done, 0);
    checkOutput("reset_err", s_err, 0);
    step();
    rst_v = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      check_vector(vecs[i], i);
    end

    // Reset landing on the commit cycle of word 3.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      frame_words[i] = W'($urandom);
      frame_par[i]   = ^frame_words[i];
    end
    start_v = 1'b1;
    step();
    start_v = 1'b0;
    l_wr.delete();
    send_header(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_word(i, 1'b1, 1'b0);
    rst_v = 1'b1;
    @(negedge clk_v);
    checkOutput("rstc_busy_before", l_busy, 1);
    checkOutput("rstc_addr_before", l_addr, 3);
    checkOutput("rstc_we", l_we, 0);
    step();
    rst_v = 1'b0;
    @(negedge clk_v);
    checkOutput("rstc_ready", l_ready, 0);
    checkOutput("rstc_word", l_word, 0);
    checkOutput("rstc_addr", l_addr, 0);
    checkOutput("rstc_we_after", l_we, 0);
    checkOutput("rstc_busy", l_busy, 0);
    checkOutput("rstc_done", l_done, 0);
    checkOutput("rstc_err", l_err, 0);
    model_frame(8'hA5, 3);
    compare_writes(1'b1, "rstc");
    step();

    // Start with a valid bit in IDLE, then a start pulse in the middle of a word.
    do_reset();
    frame_words[0] = 20'h00001;
    frame_words[1] = 20'hFFFFF;
    frame_par[0]   = 1'b1;
    frame_par[1]   = 1'b0;
    s_wr.delete();
    start_v = 1'b1;
    bit_v = 1'b1;
    bit_valid_v = 1'b1;
    @(negedge clk_v);
    checkOutput("idle_start_ready", s_ready, 0);
    step();
    start_v = 1'b0;
    bit_valid_v = 1'b0;
    send_header(8'hA5, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(frame_words[0][k], 1'b0, 0);
    start_v = 1'b1;
    step();
    @(negedge clk_v);
    checkOutput("midword_busy", s_busy, 1);
    checkOutput("midword_ready", s_ready, 1);
    checkOutput("midword_addr", s_addr, 0);
    step();
    start_v = 1'b0;
    for (int k = 5; k < W; k++) send_bit(frame_words[0][k], 1'b0, 0);
    send_bit(frame_par[0], 1'b0, 0);
    send_word(1, 1'b0, 1'b0);
    repeat (3) step();
    @(negedge clk_v);
    checkOutput("midword_done", s_done, 1);
    checkOutput("midword_err", s_err, 0);
    model_frame(8'hA5, 2);
    compare_writes(1'b0, "midword");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_config_loader.md
Name: mc_config_loader

Overview:
- Serial configuration sequencer for an array of NUM_MC macrocells.
- Accepts a framed fuse bitstream one bit per handshake and deserialises it into per-macrocell configuration words.
- Checks header and per-word parity, then issues one write strobe per word into the macrocell configuration registers. Those registers drive the pt*/xor/oe/gclk mux inputs of each cellcore instance.
- Sits between the bitstream source (file reader / JTAG model) and the macrocell array.

Parameters:
- NUM_MC, 16, number of macrocells configured per frame.
- CFG_W, 20, configuration bits per macrocell (15 single-bit muxes + 3 oe_mux + 2 gclk_mux).
- HDR, 8'hA5, frame sync header.

Ports:
- clk_v  in  1  clock; all state changes on rising edge.
- rst_v  in  1  reset, synchronous, active-high.
- start_v  in  1  begin frame; honoured in IDLE, DONE, ERR only.
- bit_v  in  1  serial data bit.
- bit_valid_v  in  1  bit_v valid this cycle.
- bit_ready_v  out  1  loader accepts a bit this cycle; a transfer occurs when valid & ready.
- cfg_word_v  out  CFG_W  deserialised word; index 0 = first bit received (pt1_mux), last two = gclk_mux.
- cfg_addr_v  out  $clog2(NUM_MC)  target macrocell index.
- cfg_we_v  out  1  one-cycle write strobe.
- busy_v  out  1  frame in progress.
- done_v  out  1  frame completed without error; level.
- err_v  out  1  frame aborted; level.

Behaviour:
- Reset: state IDLE. All outputs 0: bit_ready_v, cfg_word_v, cfg_addr_v, cfg_we_v, busy_v, done_v, err_v. Counters 0.
- State IDLE/DONE/ERR: bit_ready_v=0.
  - start_v → HDR. Clears done_v/err_v, zeroes addr and counters, sets busy_v.
  - Bits presented in these states are ignored.
  - start_v and bit_valid_v in the same cycle: the bit is not consumed.
- State HDR: bit_ready_v=1. Receives 8 bits, MSB first, into a header shift register.
  - After the 8th transfer: equal to HDR → WORD; else → ERR.
- State WORD: bit_ready_v=1. Each transfer writes bit_v to cfg_word index = bit counter (0..CFG_W-1) and updates running parity.
  - After transfer CFG_W → PAR.
- State PAR: bit_ready_v=1. One parity bit; even parity over the CFG_W data bits plus this bit.
  - Mismatch → ERR; the word is not written.
  - Match → COMMIT.
- State COMMIT: bit_ready_v=0; cfg_we_v=1 for exactly this cycle, with cfg_word_v/cfg_addr_v stable.
  - If addr==NUM_MC-1 → DONE (done_v=1, busy_v=0).
  - Else addr+1, clear bit counter and parity → WORD.
- Latency: write strobe is asserted the cycle after the parity-bit transfer.
  - Minimum frame = 8 + NUM_MC*(CFG_W+2) cycles, including COMMIT bubbles.
- ERR: err_v=1, busy_v=0. cfg_word_v/cfg_addr_v hold the value at the failure point.
  - Words committed before the error remain written; no rollback.
- Addr never wraps; the DONE transition happens before any increment past NUM_MC-1.
- start_v during HDR/WORD/PAR/COMMIT is ignored; no restart mid-frame.
- rst_v mid-frame: next cycle in IDLE, no cfg_we_v pulse, even if reset coincides with COMMIT.
- bit_valid_v gaps are permitted anywhere; state and counters hold while no transfer occurs.
- cfg_word_v changes only on accepted WORD-state transfers.

Decomposition:
- Package mc_cfg_pkg:
  - State encoding (IDLE, HDR, WORD, PAR, COMMIT, DONE, ERR).
  - HDR constant.
  - CFG_W.
  - Field offsets within the configuration word: PT1..PT5, GCLR, PT4_FUNC, PT5_FUNC, XOR_A, XOR_B, XOR_INV, D, STORAGE, FB, O, OE[3], GCLK[2]. Shared with the array wrapper that slices the word into cellcore mux inputs.
- One sub-module: cfg_shifter.
  - Indexed bit writer with bit counter and running parity.
  - Inputs: load/clear enable.
  - Outputs: word, count-terminal flag, parity.

Test Plan:
- NUM_MC=2: header A5, word0=20'h00001 + parity 1, word1=20'hFFFFF + parity 0 → exactly two cfg_we_v pulses (addr 0 word 20'h00001, addr 1 word 20'hFFFFF), then done_v=1, busy_v=0.
- Header 8'hA4 → err_v=1 after 8th bit; no cfg_we_v; bit_ready_v=0; a new start_v with a correct frame → done_v.
- Word1 with wrong parity bit → word0 written, word1 not, err_v=1, cfg_addr_v=1.
- Random 0–5 cycle bit_valid_v gaps across a full NUM_MC=16 frame → written words identical to the gap-free run; 16 strobes, addr 0..15 in order.
- rst_v asserted on the COMMIT cycle of word 3 → no strobe that cycle; all outputs 0 next cycle; state IDLE.
- start_v asserted mid-WORD and together with bit_valid_v in IDLE → no restart; the IDLE bit is not consumed (bit_ready_v=0), and the frame still decodes correctly when the bits are re-presented.
